// File: rtl/led_cmd_pkg.sv
// Shared constants, state encoding and LED update helpers for the
// UART LED command sequencer.
package led_cmd_pkg;

   localparam int NUM_LEDS = 10;

   localparam logic [7:0] CMD_HDR  = 8'h4C;
   localparam logic [7:0] CMD_ALL  = 8'h2A;
   localparam logic [7:0] OP_ON    = 8'h6E;
   localparam logic [7:0] OP_OFF   = 8'h66;
   localparam logic [7:0] OP_TGL   = 8'h74;
   localparam logic [7:0] CMD_TERM = 8'h0D;
   localparam logic [7:0] IDX_BASE = 8'h30;
   localparam logic [7:0] IDX_LAST = 8'h39;

   typedef enum logic [2:0] {
      IDLE,
      GET_IDX,
      GET_OP,
      GET_TERM,
      EXEC,
      DRAIN
   } state_t;

   typedef enum logic [1:0] {
      OPC_ON,
      OPC_OFF,
      OPC_TGL
   } opc_t;

   function automatic logic is_idx(input logic [7:0] b);
      return ((b >= IDX_BASE) && (b <= IDX_LAST)) || (b == CMD_ALL);
   endfunction

   function automatic logic is_op(input logic [7:0] b);
      return (b == OP_ON) || (b == OP_OFF) || (b == OP_TGL);
   endfunction

   function automatic opc_t op_decode(input logic [7:0] b);
      opc_t o;
      o = OPC_TGL;
      if (b == OP_ON)
         o = OPC_ON;
      else if (b == OP_OFF)
         o = OPC_OFF;
      return o;
   endfunction

   function automatic logic [NUM_LEDS-1:0] idx_mask(input logic [7:0] b);
      logic [7:0] ofs;
      ofs = b - IDX_BASE;
      if (b == CMD_ALL)
         return '1;
      return NUM_LEDS'(1) << ofs[3:0];
   endfunction

   function automatic logic [NUM_LEDS-1:0] apply_op(
      input logic [NUM_LEDS-1:0] led,
      input logic [NUM_LEDS-1:0] mask,
      input opc_t                opc
   );
      logic [NUM_LEDS-1:0] r;
      r = led;
      case (opc)
         OPC_ON:  r = led | mask;
         OPC_OFF: r = led & ~mask;
         OPC_TGL: r = led ^ mask;
         default: r = led;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// Inter-byte silence counter; expired flags the last cycle of the
// allowed wait while run is held and no clear arrives.
module cmd_timeout_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic clear,
   output logic expired
);

   localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (clear || !run)
         cnt_q <= '0;
      else if (cnt_q != LAST)
         cnt_q <= cnt_q + W'(1);
   end

   assign expired = run && (cnt_q == LAST);

endmodule

// File: rtl/led_cmd_sequencer.sv
// Parses "L<idx><op>CR" UART frames and drives ten LEDs.
// Optional inter-byte timeout: define LED_CMD_TIMEOUT_EN.
module led_cmd_sequencer
   import led_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable_clk,
   input  logic                rx_valid,
   input  logic [7:0]          rx_data,
   output logic [NUM_LEDS-1:0] LED,
   output logic                busy,
   output logic                cmd_done,
   output logic                cmd_err,
   output logic [7:0]          cmd_count
);

   state_t              state_q, state_d;
   logic [NUM_LEDS-1:0] mask_q;
   opc_t                opc_q;
   logic                accept;
   logic                expired;
   logic                err_d;
   logic                ld_mask;
   logic                ld_op;
   logic                exec_go;
   logic                hdr;

   assign accept = rx_valid && enable_clk;
   assign hdr    = (rx_data == CMD_HDR);
   assign busy   = (state_q != IDLE);

`ifdef LED_CMD_TIMEOUT_EN
   logic tmr_run;
   logic tmr_clear;

   assign tmr_run   = (state_q == GET_IDX) || (state_q == GET_OP) ||
                      (state_q == GET_TERM) || (state_q == DRAIN);
   assign tmr_clear = accept || (state_q == IDLE);

   cmd_timeout_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (tmr_run),
      .clear   (tmr_clear),
      .expired (expired)
   );
`else
   assign expired = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // An accepted byte always takes priority over a same-cycle expiry.
   always_comb begin
      state_d = state_q;
      err_d   = 1'b0;
      ld_mask = 1'b0;
      ld_op   = 1'b0;
      exec_go = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept && hdr)
               state_d = GET_IDX;
         end
         GET_IDX: begin
            if (accept) begin
               unique case (1'b1)
                  is_idx(rx_data): begin
                     state_d = GET_OP;
                     ld_mask = 1'b1;
                  end
                  hdr: state_d = GET_IDX;
                  default: begin
                     state_d = DRAIN;
                     err_d   = 1'b1;
                  end
               endcase
            end else if (expired) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end
         GET_OP: begin
            if (accept) begin
               unique case (1'b1)
                  is_op(rx_data): begin
                     state_d = GET_TERM;
                     ld_op   = 1'b1;
                  end
                  hdr: state_d = GET_IDX;
                  default: begin
                     state_d = DRAIN;
                     err_d   = 1'b1;
                  end
               endcase
            end else if (expired) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end
         GET_TERM: begin
            if (accept) begin
               unique case (1'b1)
                  rx_data == CMD_TERM: begin
                     state_d = EXEC;
                     exec_go = 1'b1;
                  end
                  hdr: state_d = GET_IDX;
                  default: begin
                     state_d = DRAIN;
                     err_d   = 1'b1;
                  end
               endcase
            end else if (expired) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end
         EXEC: state_d = IDLE;
         DRAIN: begin
            if (accept) begin
               unique case (1'b1)
                  rx_data == CMD_TERM: state_d = IDLE;
                  hdr:                 state_d = GET_IDX;
                  default:             state_d = DRAIN;
               endcase
            end else if (expired) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // LED and count update on the CR accept edge so EXEC shows the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         LED       <= '0;
         mask_q    <= '0;
         opc_q     <= OPC_ON;
         cmd_count <= '0;
         cmd_done  <= 1'b0;
         cmd_err   <= 1'b0;
      end else begin
         cmd_done <= exec_go;
         cmd_err  <= err_d;
         if (ld_mask)
            mask_q <= idx_mask(rx_data);
         if (ld_op)
            opc_q <= op_decode(rx_data);
         if (exec_go) begin
            LED       <= apply_op(LED, mask_q, opc_q);
            cmd_count <= cmd_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_led_cmd_sequencer.sv
// Randomized scoreboard bench for led_cmd_sequencer with a
// frame-level reference model.
module tb_led_cmd_sequencer;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable_clk = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [9:0] LED;
   logic       busy;
   logic       cmd_done;
   logic       cmd_err;
   logic [7:0] cmd_count;

   led_cmd_sequencer #(
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable_clk (enable_clk),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .LED        (LED),
      .busy       (busy),
      .cmd_done   (cmd_done),
      .cmd_err    (cmd_err),
      .cmd_count  (cmd_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         err;
      logic [9:0] led;
      logic [7:0] cnt;
   } ev_t;

   ev_t exp_q[$];
   int  n_chk = 0;
   int  n_pass = 0;

   // Reference model: frame text collected since the last header.
   bit         m_in = 0;
   bit         m_drain = 0;
   bit         m_exec = 0;
   logic [7:0] m_fr[$];
   logic [9:0] m_led = '0;
   logic [7:0] m_cnt = '0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] expv);
      n_chk++;
      if (act === expv)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
   endtask

   task automatic model_reset();
      m_in = 0;
      m_drain = 0;
      m_exec = 0;
      m_fr.delete();
      m_led = '0;
      m_cnt = '0;
   endtask

   task automatic model_step(input bit acc, input logic [7:0] b);
      bit         done;
      bit         ok;
      logic [9:0] mask;
      int         pos;
      done = 0;
      if (acc && !m_exec) begin
         if (b == 8'h4C) begin
            m_fr.delete();
            m_in = 1;
            m_drain = 0;
         end else if (m_drain) begin
            if (b == 8'h0D)
               m_drain = 0;
         end else if (m_in) begin
            pos = m_fr.size();
            if (pos == 0)
               ok = (b >= 8'h30 && b <= 8'h39) || b == 8'h2A;
            else if (pos == 1)
               ok = (b == "n") || (b == "f") || (b == "t");
            else
               ok = (b == 8'h0D);
            if (!ok) begin
               m_in = 0;
               m_drain = 1;
               exp_q.push_back('{1'b1, m_led, m_cnt});
            end else if (pos == 2) begin
               if (m_fr[0] == 8'h2A)
                  mask = 10'h3FF;
               else
                  mask = 10'(1) << (m_fr[0] - 8'h30);
               if (m_fr[1] == "n")
                  m_led = m_led | mask;
               else if (m_fr[1] == "f")
                  m_led = m_led & ~mask;
               else
                  m_led = m_led ^ mask;
               m_cnt = m_cnt + 8'd1;
               m_in = 0;
               done = 1;
               exp_q.push_back('{1'b0, m_led, m_cnt});
            end else begin
               m_fr.push_back(b);
            end
         end
      end
      m_exec = done;
   endtask

   task automatic drive(input bit v, input bit e, input logic [7:0] d);
      @(posedge clk);
      #1;
      rx_valid = v;
      enable_clk = e;
      rx_data = d;
      model_step(v && e, d);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b1, 8'($urandom));
   endtask

   task automatic send(input logic [7:0] b);
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
         if ($urandom_range(0, 1) == 1)
            drive(1'b1, 1'b0, 8'($urandom));
         else
            drive(1'b0, 1'b1, 8'($urandom));
      end
      drive(1'b1, 1'b1, b);
   endtask

   task automatic send4(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
      send(a);
      send(b);
      send(c);
      send(d);
   endtask

   // Monitor: every output pulse must match the next predicted event.
   always @(negedge clk) begin
      if (rst_n && (cmd_done || cmd_err)) begin
         chk("done_err_exclusive", 32'(cmd_done & cmd_err), 0);
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_pulse: got done=%0d err=%0d expected none",
                     cmd_done, cmd_err);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            chk("pulse_kind_err", 32'(cmd_err), 32'(e.err));
            chk("pulse_led", 32'(LED), 32'(e.led));
            chk("pulse_count", 32'(cmd_count), 32'(e.cnt));
         end
      end
   end

   initial begin
      logic [7:0] fr[4];
      logic [7:0] ops[3];
      ops[0] = "n";
      ops[1] = "f";
      ops[2] = "t";

      #12;
      chk("reset_led", 32'(LED), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_done", 32'(cmd_done), 0);
      chk("reset_err", 32'(cmd_err), 0);
      chk("reset_count", 32'(cmd_count), 0);
      @(negedge clk);
      rst_n = 1'b1;

      send4("L", "3", "n", 8'h0D);
      idle(3);
      chk("set3_led", 32'(LED), 32'h008);
      chk("set3_count", 32'(cmd_count), 1);

      send4("L", "*", "t", 8'h0D);
      idle(3);
      chk("tglall_led", 32'(LED), 32'h3F7);
      chk("tglall_count", 32'(cmd_count), 2);

      send("L");
      send("X");
      send4("Q", 8'h0D, "L", "0");
      send("n");
      send(8'h0D);
      idle(3);
      chk("resync_led0", 32'(LED[0]), 1);
      chk("resync_count", 32'(cmd_count), 3);

      send("L");
      send("5");
      send4("L", "5", "f", 8'h0D);
      idle(3);
      chk("restart_led", 32'(LED), 32'h3D7);
      chk("restart_count", 32'(cmd_count), 4);

      drive(1'b1, 1'b0, "L");
      drive(1'b1, 1'b0, "1");
      drive(1'b1, 1'b0, "n");
      drive(1'b1, 1'b0, 8'h0D);
      idle(3);
      chk("gated_led", 32'(LED), 32'h3D7);
      chk("gated_count", 32'(cmd_count), 4);
      chk("gated_busy", 32'(busy), 0);

`ifdef LED_CMD_TIMEOUT_EN
      send("L");
      send("2");
      m_in = 0;
      exp_q.push_back('{1'b1, m_led, m_cnt});
      idle(TO + 4);
      chk("timeout_busy", 32'(busy), 0);
      chk("timeout_led", 32'(LED), 32'(m_led));
`endif

      send("L");
      send("2");
      @(negedge clk);
      rx_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midreset_led", 32'(LED), 0);
      chk("midreset_count", 32'(cmd_count), 0);
      chk("midreset_busy", 32'(busy), 0);
      chk("midreset_err", 32'(cmd_err), 0);
      chk("midreset_pending", exp_q.size(), 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      for (int f = 0; f < 400; f++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r == 0)
            send(8'($urandom));
         fr[0] = "L";
         if ($urandom_range(0, 10) == 10)
            fr[1] = 8'h2A;
         else
            fr[1] = 8'h30 + 8'($urandom_range(0, 9));
         fr[2] = ops[$urandom_range(0, 2)];
         fr[3] = 8'h0D;
         if (r == 1)
            fr[$urandom_range(1, 3)] = 8'($urandom);
         send(fr[0]);
         send(fr[1]);
         send(fr[2]);
         if (r != 2)
            send(fr[3]);
         if ((f % 50) == 49) begin
            idle(3);
            chk("rand_led", 32'(LED), 32'(m_led));
            chk("rand_count", 32'(cmd_count), 32'(m_cnt));
         end
      end

      idle(6);
      chk("final_led", 32'(LED), 32'(m_led));
      chk("final_count", 32'(cmd_count), 32'(m_cnt));
      chk("final_queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/led_cmd_sequencer.md
LED_CMD_SEQUENCER -- requirements
Module: led_cmd_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, clk cycles of inter-byte silence that abort a partial frame.
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port enable_clk  input  1  clock enable; rx byte accepted only when high.
REQ-005 SHALL have port rx_valid  input  1  rx_data holds a received UART byte this cycle.
REQ-006 SHALL have port rx_data  input  8  received byte.
REQ-007 SHALL have port LED  output  10  registered LED states.
REQ-008 SHALL have port busy  output  1  high when FSM not in IDLE.
REQ-009 SHALL have port cmd_done  output  1  one-cycle pulse when a command is applied.
REQ-010 SHALL have port cmd_err  output  1  one-cycle pulse when a frame is aborted.
REQ-011 SHALL have port cmd_count  output  8  count of applied commands, wraps 255->0.

Function
REQ-012 SHALL accept a byte only in cycles with rx_valid=1 and enable_clk=1 ("accept"); other cycles never advance the parser.
REQ-013 SHALL parse frame 'L'(0x4C), index, op, CR(0x0D); index '0'..'9'(0x30-0x39) selects LED[0..9], '*'(0x2A) selects all ten.
REQ-014 SHALL decode op 'n'(0x6E)=set 1, 'f'(0x66)=set 0, 't'(0x74)=invert.
REQ-015 SHALL implement states IDLE, GET_IDX, GET_OP, GET_TERM, EXEC, DRAIN.
REQ-016 IDLE: accept 'L' -> GET_IDX; any other byte ignored, no error.
REQ-017 GET_IDX: valid index -> GET_OP; 'L' -> GET_IDX (resync, no error); other -> DRAIN with cmd_err pulse.
REQ-018 GET_OP: valid op -> GET_TERM; 'L' -> GET_IDX; other -> DRAIN with cmd_err pulse.
REQ-019 GET_TERM: CR -> EXEC; 'L' -> GET_IDX; other -> DRAIN with cmd_err pulse.
REQ-020 EXEC: lasts exactly one cycle, updates LED, pulses cmd_done, increments cmd_count, -> IDLE; bytes presented in EXEC are ignored.
REQ-021 DRAIN: discard bytes until CR -> IDLE, or 'L' -> GET_IDX; no further cmd_err in DRAIN.
REQ-022 LED SHALL change in the cycle after the CR accept cycle (latency 1 from CR accept to LED visible at register output).
REQ-023 Index and op SHALL be latched at accept; later rx_data changes SHALL not affect the pending command.
REQ-024 Only the addressed LED bits SHALL change; all other bits hold.
REQ-025 cmd_done and cmd_err SHALL never assert in the same cycle.

Reset
REQ-026 rst_n low SHALL asynchronously force state IDLE, LED=10'h000, busy=0, cmd_done=0, cmd_err=0, cmd_count=0, timeout counter=0.
REQ-027 Reset mid-frame SHALL discard the partial frame with no cmd_err pulse.

Configuration
REQ-028 With macro LED_CMD_TIMEOUT_EN defined: counter runs every clk in GET_IDX/GET_OP/GET_TERM/DRAIN, clears on each accept and in IDLE; on reaching TIMEOUT_CYCLES-1 FSM -> IDLE with one cmd_err pulse (DRAIN timeout: no pulse).
REQ-029 Without LED_CMD_TIMEOUT_EN: no counter logic; partial frames wait indefinitely; TIMEOUT_CYCLES unused.
REQ-030 Accept and timeout expiry in the same cycle: accept wins, counter clears.

Structure
REQ-031 Package led_cmd_pkg SHALL hold byte constants (CMD_HDR, CMD_ALL, OP_ON, OP_OFF, OP_TGL, CMD_TERM), NUM_LEDS=10, and the state encoding.
REQ-032 Timeout counter SHALL be sub-module cmd_timeout_timer (inputs clk, rst_n, run, clear; output expired), instantiated only under LED_CMD_TIMEOUT_EN.

Verification
REQ-033 Bytes 'L','3','n',CR with enable_clk=1 -> LED=10'h008 one cycle after CR, cmd_done one pulse, cmd_count=1.
REQ-034 From LED=10'h008, 'L','*','t',CR -> LED=10'h3F7, cmd_count=2.
REQ-035 'L','X' -> cmd_err pulse on 'X'; then 'Q',CR,'L','0','n',CR -> LED[0]=1, no second cmd_err.
REQ-036 'L','5' then 'L','5','f',CR -> single command, no cmd_err, LED[5]=0.
REQ-037 rx_valid=1 with enable_clk=0 for bytes 'L','1','n',CR -> no state change, LED unchanged.
REQ-038 LED_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16: 'L','2' then 16 idle cycles -> cmd_err pulse, busy=0; rst_n low mid-frame -> LED=0, no cmd_err.
